// File: rtl/timer_pkg.sv
// Shared constants for the BCD timer blocks: FSM state codes and digit limits.
package timer_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] PAUSE   = 2'd2;
    localparam logic [1:0] EXPIRED = 2'd3;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] SECH_MAX = 4'd5;

    // Wrap value for digit position idx (0 = seconds units .. 3 = tens of minutes).
    function automatic logic [3:0] digit_wrap(input int idx, input int minh_max);
        case (idx)
            0:       digit_wrap = BCD_NINE;
            1:       digit_wrap = SECH_MAX;
            2:       digit_wrap = BCD_NINE;
            default: digit_wrap = 4'(minh_max);
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with synchronous load; borrow_out chains into the next digit.
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter logic [3:0] WRAP_MAX = BCD_NINE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_reg <= 4'd0;
        end else if (load) begin
            digit_reg <= load_value;
        end else if (dec) begin
            digit_reg <= (digit_reg == 4'd0) ? WRAP_MAX : digit_reg - 4'd1;
        end
    end

    assign digit      = digit_reg;
    assign borrow_out = dec && (digit_reg == 4'd0);

endmodule

// File: rtl/countdown_mmss.sv
// MM:SS BCD countdown timer with load/start/stop control and a one-cycle Done pulse.
// Optional auto-reload on expiry is enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
module countdown_mmss
    import timer_pkg::*;
#(
    parameter int MINH_MAX = 5
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       EN,
    input  logic       Load,
    input  logic [3:0] LdMinH,
    input  logic [3:0] LdMinL,
    input  logic [3:0] LdSecH,
    input  logic [3:0] LdSecL,
    input  logic       Start,
    input  logic       Stop,
    output logic [3:0] MinH,
    output logic [3:0] MinL,
    output logic [3:0] SecH,
    output logic [3:0] SecL,
    output logic       Busy,
    output logic       Done,
    output logic       LoadErr
);

    logic [1:0]       state_reg, state_next;
    logic             done_reg, load_err_reg;
    logic [3:0][3:0]  digit_vec, preset_vec, load_vec;
    logic [3:0]       dec_vec, borrow_vec;
    logic             preset_ok, load_accept, load_reject, load_now;
    logic             in_run, dec_tick, expiring, count_zero, start_ok, reload_now;
    logic             unused_borrow;

    assign preset_vec  = {LdMinH, LdMinL, LdSecH, LdSecL};
    assign preset_ok   = (LdMinH <= 4'(MINH_MAX)) && (LdMinL <= BCD_NINE) &&
                         (LdSecH <= SECH_MAX) && (LdSecL <= BCD_NINE);
    assign in_run      = (state_reg == RUN);
    assign load_accept = Load && !in_run && preset_ok;
    assign load_reject = Load && !in_run && !preset_ok;
    assign count_zero  = (digit_vec == 16'h0000);
    assign dec_tick    = in_run && EN && !Stop;
    assign expiring    = dec_tick && (digit_vec == 16'h0001);
    // A Load in the same cycle as Start keeps the state; only the digits change.
    assign start_ok    = Start && !Stop && !Load && !count_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0] reload_reg;

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            reload_reg <= 16'h0000;
        end else if (load_accept) begin
            reload_reg <= preset_vec;
        end
    end

    assign reload_now = expiring && (reload_reg != 16'h0000);
    assign load_vec   = reload_now ? reload_reg : preset_vec;
`else
    assign reload_now = 1'b0;
    assign load_vec   = preset_vec;
`endif

    assign load_now = load_accept || reload_now;
    assign dec_vec  = {borrow_vec[2:0], dec_tick};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            bcd_digit_down #(
                .WRAP_MAX (digit_wrap(gi, MINH_MAX))
            ) u_digit (
                .clk        (CP),
                .rst_n      (nCR),
                .dec        (dec_vec[gi]),
                .load       (load_now),
                .load_value (load_vec[gi]),
                .digit      (digit_vec[gi]),
                .borrow_out (borrow_vec[gi])
            );
        end
    endgenerate

    // The tens-of-minutes borrow never fires: expiry is caught at 00:01.
    assign unused_borrow = borrow_vec[3];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, PAUSE: if (start_ok) state_next = RUN;
            RUN: begin
                if (Stop)                       state_next = PAUSE;
                else if (expiring && !reload_now) state_next = EXPIRED;
            end
            EXPIRED: if (load_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_reg    <= IDLE;
            done_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            done_reg     <= expiring;
            load_err_reg <= load_reject;
        end
    end

    assign MinH    = digit_vec[3];
    assign MinL    = digit_vec[2];
    assign SecH    = digit_vec[1];
    assign SecL    = digit_vec[0];
    assign Busy    = (state_reg == RUN);
    assign Done    = done_reg;
    assign LoadErr = load_err_reg;

endmodule

// File: doc/countdown_mmss.md
Name: countdown_mmss

Overview:
- BCD countdown timer, MM:SS format; counts toward 00:00, the opposite direction to the team's mod-24/mod-60 up-counters.
- Loaded with a BCD preset, started and stopped by the user, and decremented once per EN tick (1 Hz enable from the clock divider).
- Drives the same 4-bit-per-digit display path as the clock counters.
- Flags expiry with a one-cycle Done pulse.

Parameters:
- MINH_MAX, default 5: largest legal tens-of-minutes digit. 5 gives a 59:59 maximum; 9 gives 99:59.

Ports:
- CP  input  1  clock, rising edge
- nCR  input  1  asynchronous active-low reset
- EN  input  1  one-cycle tick; decrement enable
- Load  input  1  load preset, sampled at CP edge
- LdMinH  input  4  preset tens of minutes, BCD
- LdMinL  input  4  preset minutes units, BCD
- LdSecH  input  4  preset tens of seconds, BCD
- LdSecL  input  4  preset seconds units, BCD
- Start  input  1  start or resume, sampled at CP edge
- Stop  input  1  pause, sampled at CP edge
- MinH  output  4  current tens of minutes
- MinL  output  4  current minutes units
- SecH  output  4  current tens of seconds
- SecL  output  4  current seconds units
- Busy  output  1  high while in RUN
- Done  output  1  one-cycle expiry pulse
- LoadErr  output  1  one-cycle pulse on a rejected preset

Behaviour:
- Clock and reset: one clock, CP, rising edge. Reset nCR is asynchronous, active-low.
- Reset (any time, including mid-RUN): all digits 0, state IDLE, Busy=0, Done=0, LoadErr=0.
- States: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- Load, in IDLE, PAUSE or EXPIRED:
  - Preset is valid if LdMinH<=MINH_MAX, LdMinL<=9, LdSecH<=5 and LdSecL<=9.
  - Valid preset: the digits take the preset at that edge. EXPIRED→IDLE; IDLE and PAUSE hold their state.
  - Invalid preset: digits unchanged; LoadErr=1 for the next cycle.
- Load in RUN: ignored. No LoadErr.
- Start in IDLE or PAUSE with count != 00:00: →RUN.
- Start with count == 00:00, or in EXPIRED: ignored.
- Stop in RUN: →PAUSE. Count is frozen.
- Start and Stop in the same cycle: Stop wins. Load together with Start in IDLE: the load is applied and the state stays IDLE.
- In RUN with EN=1 and Stop=0: decrement by one second with BCD borrow.
  - SecL: 0→9 and borrow.
  - SecH: 0→5 and borrow.
  - MinL: 0→9 and borrow.
  - MinH: decrement.
- EN=1 together with Stop=1: Stop wins; no decrement on that edge.
- EN outside RUN: ignored.
- Expiry: the decrement from 00:01 to 00:00 moves the state to EXPIRED on that same edge and sets Done=1 for exactly one cycle. Busy falls on the same edge.
- Latency: every output reflects an input one CP edge after it is sampled. No combinational path from input to output.
- Out-of-range digits cannot occur after reset, because the load check rejects them.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - A reload register captures each accepted preset; reset value 00:00.
  - On expiry, the digits take the reload value on the same edge and the state stays RUN; Busy stays 1 and Done still pulses.
  - If the reload value is 00:00, the block enters EXPIRED as normal.
- Undefined: no reload register; expiry always enters EXPIRED.

Decomposition:
- Shared package timer_pkg:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3
  - BCD_NINE=4'd9
  - SECH_MAX=4'd5
- Sub-module bcd_digit_down: one BCD digit register.
  - Parameter: wrap maximum.
  - Inputs: dec, load, load value.
  - Outputs: digit, borrow_out (asserted when the digit is 0 and dec=1).
  - Instantiate four times, chaining borrow_out into the next digit's dec.

Test Plan:
- Reset mid-RUN at 12:34: assert nCR=0 asynchronously → digits 00:00, Busy=0 immediately.
- Load 01:00, Start, then 1 EN tick → 00:59. The 59 arises from SecL 0→9 and SecH 0→5 borrowing into MinL.
- Load 00:02, Start, 2 EN ticks → 00:01 then 00:00; Done high for exactly 1 cycle; state EXPIRED; a further Start is ignored.
- In RUN at 05:00, drive Stop and EN together → count stays 05:00, state PAUSE; Start → RUN; the next EN gives 04:59.
- Load LdSecH=6, and separately LdMinH=6 with MINH_MAX=5 → LoadErr pulse each time, digits unchanged. Load during RUN → ignored, no LoadErr.
- With COUNTDOWN_AUTO_RELOAD_EN defined: load 00:03, Start, 3 ticks → Done pulse, digits 00:03, Busy stays 1.
